// File: rtl/apb4_pkg.sv
// Shared types and widths for the APB4 command bridge.
package apb4_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

endpackage

// File: rtl/apb4_cmd_bridge.sv
// Valid/ready command stream to single APB4 master transfers, one outstanding at a time.
// Optional access timeout is compiled in with `define APB4_BRIDGE_TIMEOUT_EN.
module apb4_cmd_bridge
    import apb4_pkg::*;
#(
    parameter int ADDRWIDTH  = 12,
    parameter int TOUT_WIDTH = 8
) (
    input  logic                  pclk,
    input  logic                  presetn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDRWIDTH-1:0]  cmd_addr,
    input  logic [APB_DATA_W-1:0] cmd_wdata,
    input  logic [APB_STRB_W-1:0] cmd_strb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,

    output logic                  psel,
    output logic [ADDRWIDTH-1:0]  paddr,
    output logic                  penable,
    output logic                  pwrite,
    output logic [APB_DATA_W-1:0] pwdata,
    output logic [APB_STRB_W-1:0] pstrb,
    input  logic [APB_DATA_W-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    if (TOUT_WIDTH < 1) begin : g_bad_tout_width
        $error("apb4_cmd_bridge: TOUT_WIDTH must be at least 1");
    end

    apb_state_t state_q, state_d;

    logic                  psel_d, penable_d, pwrite_d;
    logic [ADDRWIDTH-1:0]  paddr_d;
    logic [APB_DATA_W-1:0] pwdata_d;
    logic [APB_STRB_W-1:0] pstrb_d;
    logic                  rsp_valid_d, rsp_err_d;
    logic [APB_DATA_W-1:0] rsp_rdata_d;
    logic                  rsp_timeout_d;
    logic                  tout_hit;

`ifdef APB4_BRIDGE_TIMEOUT_EN
    logic [TOUT_WIDTH-1:0] tout_cnt;
    logic                  rsp_timeout_q;

    // Counts ACCESS cycles spent waiting; cleared while in SETUP so it starts at 0 on entry.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tout_cnt <= '0;
        end else if (state_q == SETUP) begin
            tout_cnt <= '0;
        end else if (state_q == ACCESS && !pready) begin
            tout_cnt <= tout_cnt + 1'b1;
        end
    end

    assign tout_hit = (tout_cnt == {TOUT_WIDTH{1'b1}});

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign rsp_timeout = rsp_timeout_q;
`else
    assign tout_hit    = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    assign cmd_ready = (state_q == IDLE);

    always_comb begin
        state_d       = state_q;
        psel_d        = psel;
        penable_d     = penable;
        pwrite_d      = pwrite;
        paddr_d       = paddr;
        pwdata_d      = pwdata;
        pstrb_d       = pstrb;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_err_d     = rsp_err;
        rsp_timeout_d = rsp_timeout;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    // Reads never carry write data or strobes onto the bus.
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                    pstrb_d  = cmd_write ? cmd_strb  : '0;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // pready has priority over an expiring timeout.
                if (pready) begin
                    rsp_rdata_d   = pwrite ? '0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end else if (tout_hit) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            psel      <= psel_d;
            penable   <= penable_d;
            pwrite    <= pwrite_d;
            paddr     <= paddr_d;
            pwdata    <= pwdata_d;
            pstrb     <= pstrb_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

endmodule
